// File: rtl/shifter_sequencer.sv
// -----------------------------------------------------------------------------
// shifter_sequencer
//
// Sequences a RegisterShifter parallel-load / serial-unload datapath. A frame
// is accepted on a valid/ready handshake, the shifter is loaded with
// set_select / set strobes, and the `length` words are then presented one at a
// time on a valid/ready output handshake, with a shift + settle cycle between
// words. No data passes through this block; it only produces control.
//
// Optional feature: define SHIFTER_SEQ_ABORT_EN to add the `abort` input,
// which drops any in-flight frame and pulses shifter_reset for one cycle.
//
// Ports:
//   clk                 in   system clock, rising edge
//   reset               in   synchronous, active-high reset
//   frame_valid         in   producer has a frame on the shifter data_in bus
//   frame_ready         out  controller can accept a frame
//   word_valid          out  shifter data_out holds a valid word
//   word_ready          in   consumer takes the word
//   word_last           out  current word is word length-1
//   word_index          out  0-based index of the current word
//   shifter_set         out  drives shifter set
//   shifter_set_select  out  drives shifter set_select
//   shifter_shift       out  drives shifter shift
//   shifter_reset       out  drives shifter reset
//   abort               in   (SHIFTER_SEQ_ABORT_EN only) drop current frame
// -----------------------------------------------------------------------------
module shifter_sequencer #(
  parameter int length   = 4,
  parameter int idx_bits = $clog2(length)
) (
  input  logic                clk,
  input  logic                reset,
`ifdef SHIFTER_SEQ_ABORT_EN
  input  logic                abort,
`endif
  input  logic                frame_valid,
  output logic                frame_ready,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                word_last,
  output logic [idx_bits-1:0] word_index,
  output logic                shifter_set,
  output logic                shifter_set_select,
  output logic                shifter_shift,
  output logic                shifter_reset
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEL    = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_STREAM = 3'd4;
  localparam logic [2:0] ST_SHIFT  = 3'd5;
  localparam logic [2:0] ST_SETTLE = 3'd6;

  localparam logic [idx_bits-1:0] LAST_IDX = idx_bits'(length - 1);

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [idx_bits-1:0] idx_nxt;
  logic                abort_now;

  // Next-state logic. Outputs are decoded from the *next* state and then
  // registered, so every output is a flop and strobes change exactly on the
  // edge that enters the state they belong to.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_nxt = state;
    idx_nxt   = word_index;
    abort_now = 1'b0;

    case (state)
      ST_IDLE: begin
        // frame_ready is low for the first cycle after reset/abort, which
        // blocks a handshake until the controller really advertises ready.
        if (frame_ready && frame_valid) state_nxt = ST_SEL;
      end
      ST_SEL:  state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_HOLD;
      ST_HOLD: begin
        state_nxt = ST_STREAM;
        idx_nxt   = '0;
      end
      ST_STREAM: begin
        if (word_ready) begin
          if (word_last) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
          end else begin
            state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        // Only reached from a non-last word, so this never passes LAST_IDX.
        state_nxt = ST_SETTLE;
        idx_nxt   = word_index + 1'b1;
      end
      ST_SETTLE: state_nxt = ST_STREAM;
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
    endcase

`ifdef SHIFTER_SEQ_ABORT_EN
    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
      abort_now = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state              <= ST_IDLE;
      frame_ready        <= 1'b0;
      word_valid         <= 1'b0;
      word_last          <= 1'b0;
      word_index         <= '0;
      shifter_set        <= 1'b0;
      shifter_set_select <= 1'b0;
      shifter_shift      <= 1'b0;
      shifter_reset      <= 1'b1;
    end else begin
      state              <= state_nxt;
      word_index         <= idx_nxt;
      // An abort cycle mirrors the reset cycle: shifter held in reset and no
      // frame offered; IDLE decoding takes over on the following edge.
      frame_ready        <= (state_nxt == ST_IDLE) && !abort_now;
      shifter_reset      <= abort_now;
      // select stays high through HOLD so it is stable when set falls.
      shifter_set_select <= (state_nxt == ST_SEL) || (state_nxt == ST_LOAD) ||
                            (state_nxt == ST_HOLD);
      shifter_set        <= (state_nxt == ST_LOAD);
      shifter_shift      <= (state_nxt == ST_SHIFT);
      word_valid         <= (state_nxt == ST_STREAM);
      word_last          <= (state_nxt == ST_STREAM) && (idx_nxt == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_shifter_sequencer.sv
module tb_shifter_sequencer;

  localparam int LEN = 4;
  localparam int IW  = $clog2(LEN);

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_valid;
  logic          frame_ready;
  logic          word_valid;
  logic          word_ready;
  logic          word_last;
  logic [IW-1:0] word_index;
  logic          shifter_set;
  logic          shifter_set_select;
  logic          shifter_shift;
  logic          shifter_reset;
`ifdef SHIFTER_SEQ_ABORT_EN
  logic          abort;
`endif

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Expected {frame_ready, set_select, set, shift, word_valid, word_last}
  // for cycles T+1 .. T+14 after a frame handshake at edge T, word_ready=1.
  logic [5:0] tab[14];

  shifter_sequencer #(.length(LEN)) dut (
    .clk                (clk),
    .reset              (reset),
`ifdef SHIFTER_SEQ_ABORT_EN
    .abort              (abort),
`endif
    .frame_valid        (frame_valid),
    .frame_ready        (frame_ready),
    .word_valid         (word_valid),
    .word_ready         (word_ready),
    .word_last          (word_last),
    .word_index         (word_index),
    .shifter_set        (shifter_set),
    .shifter_set_select (shifter_set_select),
    .shifter_shift      (shifter_shift),
    .shifter_reset      (shifter_reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < LEN; i++) begin
      e.idx  = IW'(i);
      e.last = (i == LEN - 1);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each word handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      check("set_shift_overlap", {31'd0, shifter_set & shifter_shift}, 0);
      check("shift_with_select", {31'd0, shifter_shift & shifter_set_select}, 0);
      if (word_valid && word_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_word_index", word_index, e.idx);
          check("sb_word_last", word_last, e.last);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame handshake followed by a cycle-exact strobe check, word_ready held 1.
  task automatic run_timing_frame();
    logic [5:0] got;
    check("pre_frame_ready", frame_ready, 1);
    push_frame();
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) step();
      got = {frame_ready, shifter_set_select, shifter_set, shifter_shift,
             word_valid, word_last};
      check($sformatf("timing_k%0d", k), got, tab[k-1]);
      if (tab[k-1][1]) check($sformatf("timing_idx_k%0d", k), word_index, (k - 4) / 3);
    end
  endtask

  // Waits for a word, stalls `stall` cycles with word_ready=0, then takes it.
  task automatic consume_word(input int stall, input int exp_idx);
    int n = 0;
    while (!word_valid && n < 50) begin
      step();
      n++;
    end
    check("word_valid_wait", word_valid, 1);
    if (!word_valid) return;
    check("word_index_first", word_index, exp_idx);
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", word_valid, 1);
      check("stall_index", word_index, exp_idx);
      check("stall_no_shift", shifter_shift, 0);
      step();
    end
    check("stall_end_valid", word_valid, 1);
    check("stall_end_index", word_index, exp_idx);
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    check("post_hs_valid_low", word_valid, 0);
    if (exp_idx == LEN - 1) check("post_last_frame_ready", frame_ready, 1);
    else                    check("post_hs_shift", shifter_shift, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tab[0]  = 6'b010000; tab[1]  = 6'b011000; tab[2]  = 6'b010000;
    tab[3]  = 6'b000010; tab[4]  = 6'b000100; tab[5]  = 6'b000000;
    tab[6]  = 6'b000010; tab[7]  = 6'b000100; tab[8]  = 6'b000000;
    tab[9]  = 6'b000010; tab[10] = 6'b000100; tab[11] = 6'b000000;
    tab[12] = 6'b000011; tab[13] = 6'b100000;

    reset       = 1'b1;
    frame_valid = 1'b0;
    word_ready  = 1'b0;
`ifdef SHIFTER_SEQ_ABORT_EN
    abort       = 1'b0;
`endif

    // Reset and release.
    repeat (3) step();
    check("rst_shifter_reset", shifter_reset, 1);
    check("rst_outputs",
          {frame_ready, shifter_set_select, shifter_set, shifter_shift, word_valid, word_last}, 0);
    check("rst_index", word_index, 0);
    reset = 1'b0;
    step();
    check("rel_shifter_reset", shifter_reset, 0);
    check("rel_frame_ready", frame_ready, 1);
    check("rel_outputs",
          {shifter_set_select, shifter_set, shifter_shift, word_valid, word_last}, 0);
    step();

    // Cycle-exact frame with consumer always ready.
    word_ready = 1'b1;
    run_timing_frame();
    word_ready = 1'b0;

    // Stall 5 cycles on word 1.
    push_frame();
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    consume_word(0, 0);
    consume_word(5, 1);
    consume_word(0, 2);
    consume_word(2, 3);

    // Reset during SHIFT of word 2.
    push_frame();
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    consume_word(0, 0);
    consume_word(0, 1);
    consume_word(0, 2);
    reset = 1'b1;
    sb_q.delete();
    step();
    check("mid_rst_shifter_reset", shifter_reset, 1);
    check("mid_rst_outputs",
          {frame_ready, shifter_set_select, shifter_set, shifter_shift, word_valid, word_last}, 0);
    check("mid_rst_index", word_index, 0);
    reset = 1'b0;
    step();
    check("mid_rel_frame_ready", frame_ready, 1);
    word_ready = 1'b1;
    run_timing_frame();

    // frame_valid held high: back-to-back acceptance.
    push_frame();
    push_frame();
    frame_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!(word_valid && word_last) && n < 40);
    check("b2b_found_last", word_valid & word_last, 1);
    step();
    check("b2b_ready_after_last", frame_ready, 1);
    check("b2b_select_low", shifter_set_select, 0);
    step();
    check("b2b_accepted_select", shifter_set_select, 1);
    check("b2b_accepted_ready_low", frame_ready, 0);
    frame_valid = 1'b0;
    n = 0;
    while (!frame_ready && n < 40) begin
      step();
      n++;
    end
    check("b2b_second_done", frame_ready, 1);
    word_ready = 1'b0;

`ifdef SHIFTER_SEQ_ABORT_EN
    // Abort in LOAD.
    word_ready  = 1'b1;
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    step();
    check("abort_in_load", shifter_set, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_shifter_reset", shifter_reset, 1);
    check("abort_outputs",
          {frame_ready, shifter_set_select, shifter_set, shifter_shift, word_valid}, 0);
    step();
    check("abort_reset_pulse_end", shifter_reset, 0);
    check("abort_frame_ready", frame_ready, 1);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_word", word_valid, 0);
      step();
    end
    word_ready = 1'b0;
`endif

    repeat (3) step();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
